// File: rtl/mos6502_bus_tracer_if.sv
`default_nettype none
// ============================================================================
// Module   : mos6502_bus_tracer_if
// Brief    : MOS 6502 core bus bundle snooped by the trace capture block.
// Revision : 1.0 - initial release
// ============================================================================
interface mos6502_bus_tracer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic              PHI_2;
    logic              RnW;
    logic              SYNC;
    logic [ADDR_W-1:0] Address_bus;
    logic [DATA_W-1:0] Data_bus;

    modport master (output PHI_2, RnW, SYNC, Address_bus, Data_bus);
    modport slave  (input  PHI_2, RnW, SYNC, Address_bus, Data_bus);
endinterface
`default_nettype wire

// File: rtl/mos6502_bus_tracer.sv
`default_nettype none
// ============================================================================
// Module   : mos6502_bus_tracer
// Brief    : Circular trace buffer for 6502 bus cycles with watch-address
//            trigger, post-trigger window and show-ahead readout.
//            Optional macro TRACE_TIMESTAMP_EN appends a clk timestamp.
// Revision : 1.0 - initial release
// ============================================================================
module mos6502_bus_tracer #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 8,
    parameter int N_WATCH    = 2,
    parameter int POST_CNT   = 64,
    parameter int TS_W       = 16,
`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W   = ADDR_W + DATA_W + 2 + TS_W
`else
    localparam int ENTRY_W   = ADDR_W + DATA_W + 2 + (TS_W * 0)
`endif
) (
    input  wire logic                      clk,
    input  wire logic                      RES,
    mos6502_bus_tracer_if.slave            bus,
    input  wire logic                      arm,
    input  wire logic [N_WATCH*ADDR_W-1:0] watch_addr,
    input  wire logic [N_WATCH-1:0]        watch_en,
    input  wire logic                      trig_fetch,
    input  wire logic                      rd_en,
    output logic      [ENTRY_W-1:0]        rd_data,
    output logic                           rd_valid,
    output logic      [DEPTH_LOG2:0]       entry_count,
    output logic                           triggered,
    output logic                           overflow,
    output logic                           busy
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int                    c_depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_depth_cnt = (DEPTH_LOG2+1)'(c_depth);
    localparam logic [DEPTH_LOG2-1:0] c_post_load = DEPTH_LOG2'(POST_CNT);
    localparam logic [DEPTH_LOG2-1:0] c_post_last = DEPTH_LOG2'(1);

    state_t                  r_state, w_state_next;
    logic                    r_phi2_q, r_bus_rnw, r_bus_sync;
    logic [ADDR_W-1:0]       r_bus_addr;
    logic [DATA_W-1:0]       r_bus_data;
    logic [ENTRY_W-1:0]      r_ram [c_depth];
    logic [DEPTH_LOG2-1:0]   r_wr_ptr, r_rd_ptr, r_post_cnt;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_triggered, r_overflow;
    logic [N_WATCH-1:0]      w_addr_hit;
    logic                    w_cycle_done, w_match;
    logic                    w_arm_go, w_capture, w_trig, w_pop, w_rd_valid;
    logic [ENTRY_W-1:0]      w_entry;

    // Bus fields hold the last PHI_2-high sample; that sample is the entry.
    always_ff @(posedge clk) begin
        if (bus.PHI_2) begin
            r_bus_rnw  <= bus.RnW;
            r_bus_sync <= bus.SYNC;
            r_bus_addr <= bus.Address_bus;
            r_bus_data <= bus.Data_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (RES) r_phi2_q <= 1'b0;
        else     r_phi2_q <= bus.PHI_2;
    end

    assign w_cycle_done = r_phi2_q && !bus.PHI_2;

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clk) begin
        if (RES || w_arm_go) r_ts <= '0;
        else                 r_ts <= r_ts + 1'b1;
    end

    assign w_entry = {r_bus_rnw, r_bus_sync, r_bus_addr, r_bus_data, r_ts};
`else
    assign w_entry = {r_bus_rnw, r_bus_sync, r_bus_addr, r_bus_data};
`endif

    for (genvar k = 0; k < N_WATCH; k++) begin : g_watch
        assign w_addr_hit[k] = watch_en[k] &&
                               (r_bus_addr == watch_addr[k*ADDR_W +: ADDR_W]);
    end

    assign w_match = (|w_addr_hit) && (trig_fetch ? r_bus_sync : !r_bus_rnw);

    always_ff @(posedge clk) begin
        if (RES) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_arm_go     = 1'b0;
        w_capture    = 1'b0;
        w_trig       = 1'b0;
        w_rd_valid   = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_rd_valid = (r_count != '0);
                if (arm) begin
                    w_arm_go     = 1'b1;
                    w_state_next = ST_ARMED;
                end else begin
                    w_pop = rd_en && w_rd_valid;
                end
            end
            ST_ARMED: begin
                if (w_cycle_done) begin
                    w_capture = 1'b1;
                    if (w_match) begin
                        w_trig       = 1'b1;
                        w_state_next = (POST_CNT == 0) ? ST_DONE : ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (w_cycle_done) begin
                    w_capture = 1'b1;
                    if (r_post_cnt == c_post_last) w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_capture && !RES) r_ram[r_wr_ptr] <= w_entry;
    end

    // A write into a full buffer drops the oldest entry instead of growing.
    always_ff @(posedge clk) begin
        if (RES || w_arm_go) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_post_cnt  <= '0;
            r_triggered <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_count == c_depth_cnt) begin
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_overflow <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                r_count  <= r_count - 1'b1;
            end
            if (w_trig) begin
                r_triggered <= 1'b1;
                r_post_cnt  <= c_post_load;
            end else if (r_state == ST_POST && w_cycle_done) begin
                r_post_cnt <= r_post_cnt - 1'b1;
            end
        end
    end

    assign rd_valid    = w_rd_valid;
    assign rd_data     = w_rd_valid ? r_ram[r_rd_ptr] : '0;
    assign entry_count = r_count;
    assign triggered   = r_triggered;
    assign overflow    = r_overflow;
    assign busy        = (r_state == ST_ARMED) || (r_state == ST_POST);

endmodule
`default_nettype wire

// File: tb/tb_mos6502_bus_tracer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mos6502_bus_tracer
// Brief    : Randomized bench for mos6502_bus_tracer against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mos6502_bus_tracer;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DL    = 4;
    localparam int NW    = 2;
    localparam int PC    = 3;
    localparam int TSW   = 16;
    localparam int DEPTH = 1 << DL;
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = AW + DW + 2 + TSW;
`else
    localparam int EW = AW + DW + 2;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             RES, arm, trig_fetch, rd_en;
    logic [NW*AW-1:0] watch_addr;
    logic [NW-1:0]    watch_en;
    logic [EW-1:0]    rd_data;
    logic             rd_valid, triggered, overflow, busy;
    logic [DL:0]      entry_count;

    mos6502_bus_tracer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mos6502_bus_tracer #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH_LOG2(DL), .N_WATCH(NW),
        .POST_CNT(PC), .TS_W(TSW)
    ) u_dut (
        .clk(clk), .RES(RES), .bus(bus), .arm(arm), .watch_addr(watch_addr),
        .watch_en(watch_en), .trig_fetch(trig_fetch), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .entry_count(entry_count),
        .triggered(triggered), .overflow(overflow), .busy(busy)
    );

    // Reference model: list of stored entries plus capture/trigger status.
    logic [EW-1:0] mq[$];
    bit            m_active, m_trig, m_ovf, m_phi_q, m_rnw, m_sync;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [TSW-1:0] m_ts;
    int            m_post;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_update();
        logic [EW-1:0] e;
        bit hit, arm_ok;
        if (RES) begin
            mq.delete();
            m_active = 0; m_trig = 0; m_ovf = 0; m_phi_q = 0; m_ts = '0;
            return;
        end
`ifdef TRACE_TIMESTAMP_EN
        e = {m_rnw, m_sync, m_addr, m_data, m_ts};
`else
        e = {m_rnw, m_sync, m_addr, m_data};
`endif
        hit = 0;
        for (int k = 0; k < NW; k++)
            if (watch_en[k] && watch_addr[k*AW +: AW] == m_addr) hit = 1;
        hit    = hit && (trig_fetch ? m_sync : !m_rnw);
        arm_ok = arm && !m_active;
        if (arm_ok) begin
            mq.delete();
            m_active = 1; m_trig = 0; m_ovf = 0;
        end else if (m_active && m_phi_q && !bus.PHI_2) begin
            mq.push_back(e);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_ovf = 1;
            end
            if (!m_trig) begin
                if (hit) begin
                    m_trig = 1;
                    m_post = PC;
                    if (m_post == 0) m_active = 0;
                end
            end else begin
                m_post--;
                if (m_post == 0) m_active = 0;
            end
        end else if (!m_active && rd_en && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        m_ts = arm_ok ? '0 : m_ts + 1'b1;
        if (bus.PHI_2) begin
            m_rnw = bus.RnW; m_sync = bus.SYNC;
            m_addr = bus.Address_bus; m_data = bus.Data_bus;
        end
        m_phi_q = bus.PHI_2;
    endtask

    task automatic check_outputs();
        bit exp_valid;
        exp_valid = !m_active && mq.size() > 0;
        check_eq("entry_count", 64'(entry_count), 64'(mq.size()));
        check_eq("rd_valid", 64'(rd_valid), 64'(exp_valid));
        check_eq("rd_data", 64'(rd_data), exp_valid ? 64'(mq[0]) : 64'd0);
        check_eq("triggered", 64'(triggered), 64'(m_trig));
        check_eq("overflow", 64'(overflow), 64'(m_ovf));
        check_eq("busy", 64'(busy), 64'(m_active));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic bus_cycle(bit rnw, bit sync, logic [AW-1:0] addr, logic [DW-1:0] data);
        int hi;
        hi = $urandom_range(1, 3);
        bus.PHI_2 = 1'b1; bus.RnW = rnw; bus.SYNC = sync; bus.Address_bus = addr;
        for (int i = 0; i < hi; i++) begin
            bus.Data_bus = (i == hi - 1) ? data : DW'($urandom);
            tick();
        end
        bus.PHI_2 = 1'b0; bus.RnW = 1'($urandom); bus.SYNC = 1'($urandom);
        bus.Address_bus = AW'($urandom); bus.Data_bus = DW'($urandom);
        repeat ($urandom_range(1, 2)) tick();
    endtask

    task automatic pulse_arm();
        arm = 1'b1; tick(); arm = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [25:0] exp_e;
        logic [EW-1:0] first_e;
        int n;
        RES = 1'b1; arm = 1'b0; rd_en = 1'b0; trig_fetch = 1'b0;
        watch_addr = '0; watch_en = '0;
        bus.PHI_2 = 1'b0; bus.RnW = 1'b1; bus.SYNC = 1'b0;
        bus.Address_bus = '0; bus.Data_bus = '0;
        repeat (2) tick();
        RES = 1'b0;
        tick();
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_count", 64'(entry_count), 64'd0);

        // Write trigger on FFFC after ten reads.
        watch_addr = {16'h0000, 16'hFFFC}; watch_en = 2'b01; trig_fetch = 1'b0;
        pulse_arm();
        for (int i = 0; i < 10; i++) bus_cycle(1'b1, 1'($urandom), 16'h1000 + AW'(i), DW'($urandom));
        bus_cycle(1'b0, 1'b0, 16'hFFFC, 8'hA5);
        for (int i = 0; i < PC; i++) bus_cycle(1'($urandom), 1'b0, 16'h2000 + AW'(i), DW'($urandom));
        check_eq("wt_count", 64'(entry_count), 64'd14);
        check_eq("wt_triggered", 64'(triggered), 64'd1);
        check_eq("wt_overflow", 64'(overflow), 64'd0);
        check_eq("wt_oldest_addr", 64'(rd_data[EW-3 -: AW]), 64'h1000);
        for (int i = 0; i < 3; i++) begin
            pop();
            tick();
            check_eq("wt_pop_count", 64'(entry_count), 64'(13 - i));
        end
        repeat (7) pop();
        exp_e = {2'b00, 16'hFFFC, 8'hA5};
        check_eq("wt_trigger_entry", 64'(rd_data[EW-1 -: 26]), 64'(exp_e));
        repeat (4) pop();
        check_eq("wt_drained", 64'(rd_valid), 64'd0);
        pop();
        check_eq("wt_empty_pop", 64'(entry_count), 64'd0);

        // Wrap and overflow: 40 cycles, trigger on the 40th.
        watch_addr = {16'h0000, 16'd39}; watch_en = 2'b01;
        pulse_arm();
        for (int a = 0; a < 39; a++) bus_cycle(1'b1, 1'b0, AW'(a), DW'($urandom));
        bus_cycle(1'b0, 1'b0, 16'd39, DW'($urandom));
        for (int a = 40; a < 43; a++) bus_cycle(1'($urandom), 1'b0, AW'(a), DW'($urandom));
        check_eq("wrap_count", 64'(entry_count), 64'd16);
        check_eq("wrap_overflow", 64'(overflow), 64'd1);
        check_eq("wrap_first_addr", 64'(rd_data[EW-3 -: AW]), 64'd27);
        repeat (15) pop();
        check_eq("wrap_last_addr", 64'(rd_data[EW-3 -: AW]), 64'd42);
        pop();

        // Fetch trigger on comparator 1 only.
        watch_addr = {16'h0400, 16'h0400}; watch_en = 2'b10; trig_fetch = 1'b1;
        pulse_arm();
        bus_cycle(1'b0, 1'b0, 16'h0400, 8'h11);
        bus_cycle(1'b1, 1'b0, 16'h0400, 8'h22);
        check_eq("fetch_no_trig", 64'(triggered), 64'd0);
        bus_cycle(1'b1, 1'b1, 16'h0400, 8'hEA);
        check_eq("fetch_trig", 64'(triggered), 64'd1);

        // Reset in the middle of the post-trigger window.
        bus_cycle(1'b1, 1'b0, 16'h0500, 8'h33);
        check_eq("mid_post_busy", 64'(busy), 64'd1);
        RES = 1'b1; repeat (2) tick(); RES = 1'b0;
        tick();
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_count", 64'(entry_count), 64'd0);
        check_eq("rst_valid", 64'(rd_valid), 64'd0);
        check_eq("rst_trig", 64'(triggered), 64'd0);
        check_eq("rst_ovf", 64'(overflow), 64'd0);

`ifdef TRACE_TIMESTAMP_EN
        // Completions 5 and 9 clocks after the arm edge.
        watch_addr = {16'h0000, 16'h0777}; watch_en = 2'b01; trig_fetch = 1'b0;
        bus.RnW = 1'b0; bus.SYNC = 1'b0; bus.Address_bus = 16'h0100;
        pulse_arm();
        bus.PHI_2 = 1'b1; repeat (4) tick();
        bus.PHI_2 = 1'b0; tick();
        bus.Address_bus = 16'h0777;
        bus.PHI_2 = 1'b1; repeat (3) tick();
        bus.PHI_2 = 1'b0; tick();
        for (int i = 0; i < PC; i++) bus_cycle(1'b1, 1'b0, 16'h0200, DW'($urandom));
        first_e = rd_data;
        pop();
        check_eq("ts_delta", 64'(rd_data[TSW-1:0] - first_e[TSW-1:0]), 64'd4);
        repeat (PC + 1) pop();
`endif

        // Randomized capture rounds over a small address window.
        for (int r = 0; r < 25; r++) begin
            watch_addr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            watch_en   = NW'($urandom);
            trig_fetch = 1'($urandom);
            pulse_arm();
            n = $urandom_range(5, 40);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 9) == 0) begin arm = 1'b1; rd_en = 1'b1; end
                bus_cycle(1'($urandom), 1'($urandom), AW'($urandom_range(0, 15)), DW'($urandom));
                arm = 1'b0; rd_en = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) begin
                RES = 1'b1; tick(); RES = 1'b0;
            end
            repeat ($urandom_range(0, 20)) begin
                rd_en = 1'($urandom); tick();
            end
            rd_en = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mos6502_bus_tracer.md
Name: mos6502_bus_tracer

Overview:
- Synthesizable on-chip trace capture for the MOS_6502 core bus. It takes over the stop-on-write and bus-check role of the simulation self-test harness.
- Snoops completed bus cycles into a parametrised circular trace buffer.
- Stops on a programmable watch-address event, then captures a fixed post-trigger window.
- Exposes a show-ahead readout port for a debug UART or host.

Parameters:
ADDR_W, 16, bus address width
DATA_W, 8, bus data width
DEPTH_LOG2, 8, log2 of trace entries (DEPTH = 2**DEPTH_LOG2)
N_WATCH, 2, number of watch-address comparators
POST_CNT, 64, entries captured after trigger; must satisfy 0 <= POST_CNT <= DEPTH-1
TS_W, 16, timestamp width (used only with TRACE_TIMESTAMP_EN)

Ports:
clk  in  1  system clock
RES  in  1  synchronous active-high reset
PHI_2  in  1  CPU phase-2 clock enable, sampled on clk
RnW  in  1  CPU read/not-write
SYNC  in  1  CPU opcode-fetch flag
Address_bus  in  ADDR_W  CPU address
Data_bus  in  DATA_W  CPU data, as seen on the bus
arm  in  1  start capture (pulse)
watch_addr  in  N_WATCH*ADDR_W  packed watch addresses, comparator k in bits [k*ADDR_W +: ADDR_W]
watch_en  in  N_WATCH  per-comparator enable
trig_fetch  in  1  0: trigger on write to a watch address; 1: trigger on SYNC fetch from a watch address
rd_en  in  1  pop oldest entry
rd_data  out  ADDR_W+DATA_W+2 (+TS_W)  entry {RnW, SYNC, Address, Data [, timestamp]}
rd_valid  out  1  rd_data holds an unread entry
entry_count  out  DEPTH_LOG2+1  entries held
triggered  out  1  trigger has occurred since arm
overflow  out  1  pre-trigger entries were overwritten
busy  out  1  state is ARMED or POST

Behaviour:
- Reset: synchronous, active-high, applied on clk while RES=1.
  - State goes to IDLE; pointers, entry_count, triggered and overflow are cleared.
  - All outputs read 0 (rd_data = 0 because rd_valid = 0). RAM contents are not cleared.
  - RES mid-capture aborts the capture immediately.
- Cycle completion:
  - Bus fields (RnW, SYNC, Address_bus, Data_bus) are registered every clk while PHI_2=1.
  - A completed cycle is detected on clk where PHI_2_q=1 and PHI_2=0.
  - The entry is the last registered PHI_2-high sample. It is written to RAM on the same clk edge as detection.
  - entry_count updates 1 clk after the falling PHI_2.
- Watch match: any k with watch_en[k] and Address==watch_addr[k], qualified as follows:
  - trig_fetch=0: RnW=0.
  - trig_fetch=1: SYNC=1.
- State machine:
  - IDLE: arm -> ARMED (clears pointers, count and flags).
  - ARMED: each completed cycle is written at wr_ptr.
    - entry_count saturates at DEPTH.
    - A write while full advances rd_ptr (oldest dropped) and sets overflow.
    - A watch match on the completed cycle stores that entry, sets triggered, and loads post counter = POST_CNT.
    - If POST_CNT==0 the next state is DONE; otherwise POST.
  - POST: each completed cycle is stored (same overwrite rules) and decrements the post counter; at 0 -> DONE. Further watch matches are ignored.
  - DONE: no capture. The buffer holds min(total, DEPTH) entries ending with the last post entry. arm -> ARMED (restart).
  - arm is ignored in ARMED/POST. Readout is legal only in IDLE/DONE; rd_en is ignored elsewhere.
- Readout:
  - rd_data is show-ahead: it equals RAM[rd_ptr] whenever rd_valid=1.
  - rd_valid = (entry_count != 0) and state in {IDLE, DONE}.
  - rd_en with rd_valid: rd_ptr++ (wraps modulo DEPTH), entry_count-- the next clk. rd_en with rd_valid=0 has no effect.
- Pointer arithmetic: modulo DEPTH; entry_count is DEPTH_LOG2+1 bits so that DEPTH is representable.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - A TS_W-bit free-running clk counter is cleared by RES and by arm, and wraps.
  - The counter value at cycle completion is appended as the LSBs of each entry; rd_data widens by TS_W.
- Undefined: no counter; entries and rd_data are ADDR_W+DATA_W+2 bits.

Test Plan:
- Reset: drive RES=1 for 2 clk mid-POST -> next clk: busy=0, entry_count=0, rd_valid=0, triggered=0, overflow=0.
- Write trigger: arm, watch_addr[0]=16'hFFFC, watch_en=2'b01, trig_fetch=0; 10 reads, then write 8'hA5 to FFFC, then 64 cycles -> DONE; entry_count=75; oldest entry is first read; entry 11 = {0,0,FFFC,A5}; triggered=1, overflow=0.
- Wrap and overflow: DEPTH_LOG2=4, POST_CNT=3; 40 cycles at addresses 0..39, trigger on 39 (write), then 3 cycles -> entry_count=16; overflow=1; first read address 27, last 42.
- Fetch trigger: trig_fetch=1, watch_addr[1]=16'h0400, watch_en=2'b10; a write to 0400 -> no trigger; a SYNC fetch at 0400 -> triggered=1.
- Readout handshake: in DONE, pulse rd_en 3 times, then rd_en with rd_valid=0 -> entry_count drops by 3 then holds; rd_data changes only after each accepted pop.
- TRACE_TIMESTAMP_EN: arm, with cycles completing at clk 5 and 9 after arm -> timestamps differ by 4.
